// File: rtl/ofdm_rx_pkg.sv
// Shared definitions for the OFDM RX symbol framer: FSM state codes,
// derived symbol geometry and counter-width helpers.
package ofdm_rx_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_CP      = 2'd1;
  localparam state_t ST_PAYLOAD = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

  // Cyclic-prefix length in input samples.
  function automatic int cp_len(input int sym_len, input int raw_len);
    return sym_len - raw_len;
  endfunction

  // Decimated payload samples emitted per symbol.
  function automatic int out_per_sym(input int raw_len, input int osr);
    return raw_len / osr;
  endfunction

  // Bits needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ofdm_rx_decim_phase.sv
// Decimation phase tracker: holds the latched phase and the running
// phase counter, and flags which payload sample is to be forwarded.
// The compare uses the incoming phase on the load cycle so that a symbol
// with no cyclic prefix can forward its very first sample.
module ofdm_rx_decim_phase
  import ofdm_rx_pkg::*;
#(
  parameter  int OSR = 4,
  localparam int PW  = cnt_w(OSR)
) (
  input  logic          sys_clk,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [PW-1:0] i_phase,
  input  logic          i_restart,
  input  logic          i_adv,
  output logic          o_fwd
);

  localparam logic [PW-1:0] C_PH_LAST = PW'(OSR - 1);

  logic [PW-1:0] r_ph;
  logic [PW-1:0] r_phase;
  logic [PW-1:0] w_ph;
  logic [PW-1:0] w_phase;
  logic [PW-1:0] w_ph_nxt;

  // Effective counter/phase for the current sample, including a load in flight.
  always_comb begin
    w_ph     = i_load ? '0 : r_ph;
    w_phase  = i_load ? i_phase : r_phase;
    w_ph_nxt = (w_ph == C_PH_LAST) ? '0 : w_ph + 1'b1;
    o_fwd    = (w_ph == w_phase);
  end

  // Phase latch and wrapping phase counter.
  always_ff @(posedge sys_clk) begin
    if (i_clr) begin
      r_ph    <= '0;
      r_phase <= '0;
    end else begin
      if (i_load) r_phase <= i_phase;
      if (i_adv)                      r_ph <= w_ph_nxt;
      else if (i_load || i_restart)   r_ph <= '0;
    end
  end

endmodule

// File: rtl/ofdm_rx_symbol_framer.sv
// OFDM RX symbol framer: strips the cyclic prefix, decimates the payload
// by OSR at a selectable phase and frames SEQUENCE_LENGTH contiguous
// symbols into one sequence, pulsing seq_done at the end.
// Optional macro OFDM_FRAMER_REALIGN_EN: a strobe during CP/PAYLOAD
// restarts the current symbol and adds the realign_pulse output.
module ofdm_rx_symbol_framer
  import ofdm_rx_pkg::*;
#(
  parameter  int SAMPLE_BIT_WIDTH  = 12,
  parameter  int SYMBOL_LENGTH     = 320,
  parameter  int RAW_SYMBOL_LENGTH = 256,
  parameter  int OSR               = 4,
  parameter  int SEQUENCE_LENGTH   = 20,
  localparam int PW                = cnt_w(OSR),
  localparam int QW                = cnt_w(SEQUENCE_LENGTH)
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        sys_init,
  input  logic [SAMPLE_BIT_WIDTH-1:0] rx_data_i,
  input  logic [SAMPLE_BIT_WIDTH-1:0] rx_data_q,
  input  logic                        rx_data_valid,
  input  logic                        align_strobe,
  input  logic [PW-1:0]               phase_sel,
  output logic [SAMPLE_BIT_WIDTH-1:0] sym_data_i,
  output logic [SAMPLE_BIT_WIDTH-1:0] sym_data_q,
  output logic                        sym_data_valid,
  output logic                        sym_data_start,
  output logic [QW-1:0]               sym_index,
`ifdef OFDM_FRAMER_REALIGN_EN
  output logic                        realign_pulse,
`endif
  output logic                        seq_done
);

  localparam int SW     = cnt_w(SYMBOL_LENGTH);
  localparam int CP_LEN = cp_len(SYMBOL_LENGTH, RAW_SYMBOL_LENGTH);

  localparam logic [SW-1:0] C_CP_LAST  = SW'(CP_LEN - 1);
  localparam logic [SW-1:0] C_SYM_LAST = SW'(SYMBOL_LENGTH - 1);
  localparam logic [QW-1:0] C_SEQ_LAST = QW'(SEQUENCE_LENGTH - 1);
  localparam bit            C_CP_NONE  = (CP_LEN == 0);
  localparam bit            C_CP_SHORT = (CP_LEN <= 1);

  state_t                      r_state;
  logic [SW-1:0]               r_smp;
  logic [QW-1:0]               r_sym;
  logic [SAMPLE_BIT_WIDTH-1:0] r_di;
  logic [SAMPLE_BIT_WIDTH-1:0] r_dq;
  logic                        r_valid;
  logic                        r_start;
  logic [QW-1:0]               r_idx;
  logic                        r_seq_done;

  logic          w_clr;
  logic          w_in_run;
  logic          w_realign;
  logic          w_start_acc;
  logic          w_pay_smp;
  logic          w_cp_done;
  logic          w_fwd_en;
  logic          w_fwd;
  logic [SW-1:0] w_smp_cur;

  // Qualify the current input sample against the FSM state.
  always_comb begin
    w_clr     = sys_rst | sys_init;
    w_in_run  = (r_state == ST_CP) || (r_state == ST_PAYLOAD);
`ifdef OFDM_FRAMER_REALIGN_EN
    w_realign = rx_data_valid & align_strobe & w_in_run;
`else
    w_realign = 1'b0;
`endif
    w_start_acc = (rx_data_valid & align_strobe & (r_state == ST_IDLE)) | w_realign;
    // A restarted symbol's index-0 sample is payload only when there is no CP.
    w_pay_smp   = rx_data_valid & (w_start_acc ? C_CP_NONE : (r_state == ST_PAYLOAD));
    w_cp_done   = rx_data_valid & ~w_start_acc & (r_state == ST_CP) & (r_smp == C_CP_LAST);
    w_smp_cur   = w_start_acc ? '0 : r_smp;
    w_fwd       = w_pay_smp & w_fwd_en;
  end

  ofdm_rx_decim_phase #(.OSR(OSR)) u_phase (
    .sys_clk   (sys_clk),
    .i_clr     (w_clr),
    .i_load    (w_start_acc),
    .i_phase   (phase_sel),
    .i_restart (w_cp_done),
    .i_adv     (w_pay_smp),
    .o_fwd     (w_fwd_en)
  );

  // Symbol/sequence FSM with sample and symbol counters.
  always_ff @(posedge sys_clk) begin
    if (w_clr) begin
      r_state    <= ST_IDLE;
      r_smp      <= '0;
      r_sym      <= '0;
      r_seq_done <= 1'b0;
    end else begin
      r_seq_done <= 1'b0;
      if (r_state == ST_DONE) begin
        r_state <= ST_IDLE;
        r_sym   <= '0;
      end else if (w_start_acc) begin
        r_smp   <= SW'(1);
        r_state <= C_CP_SHORT ? ST_PAYLOAD : ST_CP;
      end else if (rx_data_valid && w_in_run) begin
        if (r_state == ST_CP) begin
          r_smp <= r_smp + 1'b1;
          if (r_smp == C_CP_LAST) r_state <= ST_PAYLOAD;
        end else if (r_smp == C_SYM_LAST) begin
          r_smp <= '0;
          if (r_sym == C_SEQ_LAST) begin
            r_state    <= ST_DONE;
            r_seq_done <= 1'b1;
          end else begin
            r_sym   <= r_sym + 1'b1;
            r_state <= C_CP_NONE ? ST_PAYLOAD : ST_CP;
          end
        end else begin
          r_smp <= r_smp + 1'b1;
        end
      end
    end
  end

  // Registered output stage; data and index hold between forwarded samples.
  always_ff @(posedge sys_clk) begin
    if (w_clr) begin
      r_di    <= '0;
      r_dq    <= '0;
      r_valid <= 1'b0;
      r_start <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_valid <= w_fwd;
      r_start <= w_fwd & (int'(w_smp_cur) < CP_LEN + OSR);
      if (w_fwd) begin
        r_di  <= rx_data_i;
        r_dq  <= rx_data_q;
        r_idx <= r_sym;
      end
    end
  end

`ifdef OFDM_FRAMER_REALIGN_EN
  logic r_realign_pulse;

  // One-cycle flag after each accepted realignment.
  always_ff @(posedge sys_clk) begin
    if (w_clr) r_realign_pulse <= 1'b0;
    else       r_realign_pulse <= w_realign;
  end

  assign realign_pulse = r_realign_pulse;
`endif

  assign sym_data_i     = r_di;
  assign sym_data_q     = r_dq;
  assign sym_data_valid = r_valid;
  assign sym_data_start = r_start;
  assign sym_index      = r_idx;
  assign seq_done       = r_seq_done;

endmodule

// File: tb/tb_ofdm_rx_symbol_framer.sv
// Directed bench for ofdm_rx_symbol_framer: ramp stimulus scenarios from a
// vector table, plus hand-written sys_init and repeated-strobe sequences.
// A second instance covers the 80/64/OSR-1/2-symbol parameter set.
module tb_ofdm_rx_symbol_framer;

  logic        sys_clk = 1'b0;
  logic        sys_rst, sys_init, rx_data_valid, align_strobe;
  logic [11:0] rx_data_i, rx_data_q;
  logic [1:0]  phase_sel;
  logic        phase_sel2;

  logic [11:0] sym_data_i, sym_data_q;
  logic        sym_data_valid, sym_data_start, seq_done;
  logic [4:0]  sym_index;
`ifdef OFDM_FRAMER_REALIGN_EN
  logic        realign_pulse;
`endif

  logic [11:0] d2_i, d2_q;
  logic        d2_valid, d2_start, d2_done;
  logic [0:0]  d2_idx;

  always #5 sys_clk = ~sys_clk;

  ofdm_rx_symbol_framer dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sys_init(sys_init),
    .rx_data_i(rx_data_i), .rx_data_q(rx_data_q), .rx_data_valid(rx_data_valid),
    .align_strobe(align_strobe), .phase_sel(phase_sel),
    .sym_data_i(sym_data_i), .sym_data_q(sym_data_q), .sym_data_valid(sym_data_valid),
    .sym_data_start(sym_data_start), .sym_index(sym_index),
`ifdef OFDM_FRAMER_REALIGN_EN
    .realign_pulse(realign_pulse),
`endif
    .seq_done(seq_done)
  );

  ofdm_rx_symbol_framer #(.SYMBOL_LENGTH(80), .RAW_SYMBOL_LENGTH(64), .OSR(1),
                          .SEQUENCE_LENGTH(2)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sys_init(sys_init),
    .rx_data_i(rx_data_i), .rx_data_q(rx_data_q), .rx_data_valid(rx_data_valid),
    .align_strobe(align_strobe), .phase_sel(phase_sel2),
    .sym_data_i(d2_i), .sym_data_q(d2_q), .sym_data_valid(d2_valid),
    .sym_data_start(d2_start), .sym_index(d2_idx), .seq_done(d2_done)
  );

  typedef struct {int v; int q; bit st; int idx; int pos;} rec_t;
  typedef struct {int phase; bit toggle; int first; int last; int count; int done_pos;} vec_t;

  rec_t oq[$];
  rec_t oq2[$];
  int   dq[$];
  int   dq2[$];
  int   rq[$];
  int   nvec = 0;
  int   nfail = 0;
  int   cur_tag;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle, then capture whatever the DUTs emit for it.
  task automatic step(input bit v, input bit s, input int n, input bit init);
    rx_data_valid = v;
    align_strobe  = s;
    sys_init      = init;
    if (v) begin
      rx_data_i = 12'(n);
      rx_data_q = 12'(n) ^ 12'h5A5;
      cur_tag   = n;
    end else begin
      rx_data_i = 12'hABC;
      rx_data_q = 12'h123;
      cur_tag   = -1;
    end
    @(posedge sys_clk); #1;
    if (sym_data_valid)
      oq.push_back('{int'(sym_data_i), int'(sym_data_q), sym_data_start, int'(sym_index), cur_tag});
    if (d2_valid)
      oq2.push_back('{int'(d2_i), int'(d2_q), d2_start, int'(d2_idx), cur_tag});
    if (seq_done) dq.push_back(cur_tag);
    if (d2_done)  dq2.push_back(cur_tag);
`ifdef OFDM_FRAMER_REALIGN_EN
    if (realign_pulse) rq.push_back(cur_tag);
`endif
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    sys_rst = 1'b0;
    oq.delete(); oq2.delete(); dq.delete(); dq2.delete(); rq.delete();
  endtask

  vec_t vt[3];

  initial begin
    int exp, sz, fi;
    sys_rst = 1'b0; sys_init = 1'b0; rx_data_valid = 1'b0; align_strobe = 1'b0;
    rx_data_i = '0; rx_data_q = '0; phase_sel = '0; phase_sel2 = 1'b0;

    vt[0] = '{0, 1'b0, 64, 6396 % 4096, 1280, 6399};
    vt[1] = '{3, 1'b0, 67, 6399 % 4096, 1280, 6399};
    vt[2] = '{0, 1'b1, 64, 6396 % 4096, 1280, 6399};

    do_reset();
    chk("rst_valid", int'(sym_data_valid), 0);
    chk("rst_data_i", int'(sym_data_i), 0);
    chk("rst_data_q", int'(sym_data_q), 0);
    chk("rst_start", int'(sym_data_start), 0);
    chk("rst_index", int'(sym_index), 0);
    chk("rst_done", int'(seq_done), 0);
    chk("rst2_valid", int'(d2_valid), 0);
    chk("rst2_data_i", int'(d2_i), 0);

    // Full-sequence ramp scenarios.
    for (int t = 0; t < 3; t++) begin
      do_reset();
      phase_sel = 2'(vt[t].phase);
      for (int n = 0; n < 6400; n++) begin
        step(1, n == 0, n, 0);
        if (vt[t].toggle) step(0, 1, 0, 0);
      end
      for (int g = 0; g < 6; g++) step(0, 0, 0, 0);
      chk($sformatf("s%0d_count", t), oq.size(), vt[t].count);
      chk($sformatf("s%0d_first", t), (oq.size() > 0) ? oq[0].v : -1, vt[t].first);
      chk($sformatf("s%0d_last", t), (oq.size() > 0) ? oq[oq.size()-1].v : -1, vt[t].last);
      chk($sformatf("s%0d_ndone", t), dq.size(), 1);
      chk($sformatf("s%0d_done_pos", t), (dq.size() > 0) ? dq[0] : -1, vt[t].done_pos);
      chk($sformatf("s%0d_idle_valid", t), int'(sym_data_valid), 0);
      chk($sformatf("s%0d_hold", t), int'(sym_data_i), vt[t].last);
      for (int k = 0; k < oq.size() && k < 1280; k++) begin
        exp = 64 + vt[t].phase + (k / 64) * 320 + (k % 64) * 4;
        chk($sformatf("s%0d_i[%0d]", t, k), oq[k].v, exp % 4096);
        chk($sformatf("s%0d_q[%0d]", t, k), oq[k].q, (exp % 4096) ^ 'h5A5);
        chk($sformatf("s%0d_start[%0d]", t, k), int'(oq[k].st), (k % 64 == 0) ? 1 : 0);
        chk($sformatf("s%0d_idx[%0d]", t, k), oq[k].idx, k / 64);
        chk($sformatf("s%0d_lat[%0d]", t, k), oq[k].pos, exp);
      end
      if (t == 0) begin
        chk("p2_count", oq2.size(), 128);
        chk("p2_ndone", dq2.size(), 1);
        chk("p2_done_pos", (dq2.size() > 0) ? dq2[0] : -1, 159);
        for (int k = 0; k < oq2.size() && k < 128; k++) begin
          exp = 16 + (k / 64) * 80 + (k % 64);
          chk($sformatf("p2_i[%0d]", k), oq2[k].v, exp);
          chk($sformatf("p2_start[%0d]", k), int'(oq2[k].st), (k % 64 == 0) ? 1 : 0);
          chk($sformatf("p2_idx[%0d]", k), oq2[k].idx, k / 64);
          chk($sformatf("p2_lat[%0d]", k), oq2[k].pos, exp);
        end
      end
    end

    // sys_init mid symbol 1, then a fresh strobe at sample 1000.
    do_reset();
    phase_sel = 2'd0;
    for (int n = 0; n < 500; n++) step(1, n == 0, n, 0);
    chk("init_pre_count", oq.size(), 93);
    chk("init_pre_hold", int'(sym_data_i), 496);
    chk("init_pre_idx", int'(sym_index), 1);
    step(1, 0, 500, 1);
    chk("init_valid", int'(sym_data_valid), 0);
    chk("init_data_i", int'(sym_data_i), 0);
    chk("init_data_q", int'(sym_data_q), 0);
    chk("init_index", int'(sym_index), 0);
    sz = oq.size();
    step(0, 1, 0, 0);
    for (int n = 501; n < 1000; n++) step(1, 0, n, 0);
    chk("init_idle_quiet", oq.size(), sz);
    for (int n = 1000; n <= 1100; n++) step(1, n == 1000, n, 0);
    chk("init_restart_count", oq.size() - sz, 10);
    chk("init_restart_first", (oq.size() > sz) ? oq[sz].v : -1, 1064);
    chk("init_restart_start", (oq.size() > sz) ? int'(oq[sz].st) : -1, 1);
    chk("init_restart_idx", (oq.size() > sz) ? oq[sz].idx : -1, 0);

    // Strobe repeated inside the payload at sample 100.
    do_reset();
    for (int n = 0; n <= 200; n++) step(1, n == 0 || n == 100, n, 0);
    fi = -1;
    for (int k = oq.size() - 1; k >= 0; k--) if (oq[k].pos > 100) fi = k;
`ifdef OFDM_FRAMER_REALIGN_EN
    chk("rs_count", oq.size(), 19);
    chk("rs_next", (fi >= 0) ? oq[fi].v : -1, 164);
    chk("rs_next_start", (fi >= 0) ? int'(oq[fi].st) : -1, 1);
    chk("rs_npulse", rq.size(), 1);
    chk("rs_pulse_pos", (rq.size() > 0) ? rq[0] : -1, 100);
`else
    chk("rs_count", oq.size(), 35);
    chk("rs_next", (fi >= 0) ? oq[fi].v : -1, 104);
    chk("rs_next_start", (fi >= 0) ? int'(oq[fi].st) : -1, 0);
`endif
    chk("rs_next_idx", (fi >= 0) ? oq[fi].idx : -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
